// File: rtl/m1_stage.sv
// First memory stage: holds one instruction, issues the dcache address/store
// request, and forwards the result. `ADDR_ERR_CHECK_EN enables misaligned-address exceptions.
module m1_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         es_to_m1s_valid,
  output logic         m1s_allowin,
  input  logic [116:0] es_to_m1s_bus,
  input  logic         ms_allowin,
  output logic         m1s_to_ms_valid,
  output logic [148:0] m1s_to_ms_bus,
  input  logic         flush,
  input  logic [31:0]  CP0_data,
  output logic         data_req,
  output logic         data_wr,
  output logic [3:0]   data_wstrb,
  output logic [31:0]  data_addr,
  output logic [31:0]  data_wdata,
  input  logic         data_addr_ok,
  output logic [4:0]   M1_dest,
  output logic [31:0]  M1_result,
  output logic         m1s_ex
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic         m1s_valid_q, m1s_valid_d;
  logic [116:0] bus_q, bus_d;
  logic [1:0]   state_q, state_d;

  logic         mfc0, ex_in, gr_we;
  logic [31:0]  rt_value, alu_result;
  logic [11:0]  mem_inst;
  logic [4:0]   dest;
  logic [1:0]   a;
  logic         mem_op, addr_err, ex, ready_go, handshake;

  assign mfc0       = bus_q[116];
  assign ex_in      = bus_q[115];
  assign rt_value   = bus_q[114:83];
  assign mem_inst   = bus_q[82:71];
  assign gr_we      = bus_q[69];
  assign dest       = bus_q[68:64];
  assign alu_result = bus_q[63:32];
  assign a          = alu_result[1:0];

  assign mem_op = |mem_inst;
`ifdef ADDR_ERR_CHECK_EN
  assign addr_err = ((mem_inst[0] | mem_inst[1]) & (a != 2'b00))
                  | ((mem_inst[4] | mem_inst[5] | mem_inst[9]) & a[0]);
`else
  assign addr_err = 1'b0;
`endif
  assign ex = ex_in | addr_err;

  assign data_req  = m1s_valid_q & mem_op & ~ex & ~flush & (state_q != DONE);
  assign handshake = data_req & data_addr_ok;
  assign ready_go  = ~mem_op | ex | (state_q == DONE) | handshake;

  assign m1s_allowin     = ~m1s_valid_q | (ready_go & ms_allowin);
  assign m1s_to_ms_valid = m1s_valid_q & ready_go & ~flush;

  assign data_addr = {alu_result[31:2], 2'b00};
  assign data_wr   = mem_inst[1] | mem_inst[8] | mem_inst[9] | mem_inst[10] | mem_inst[11];

  always_comb begin
    data_wstrb = '0;
    data_wdata = '0;
    if (mem_inst[1]) begin
      data_wstrb = 4'b1111;
      data_wdata = rt_value;
    end else if (mem_inst[8]) begin
      data_wstrb = 4'b0001 << a;
      data_wdata = {4{rt_value[7:0]}};
    end else if (mem_inst[9]) begin
      data_wstrb = a[1] ? 4'b1100 : 4'b0011;
      data_wdata = {2{rt_value[15:0]}};
    end else if (mem_inst[10]) begin
      case (a)
        2'd0:    begin data_wstrb = 4'b0001; data_wdata = rt_value >> 24; end
        2'd1:    begin data_wstrb = 4'b0011; data_wdata = rt_value >> 16; end
        2'd2:    begin data_wstrb = 4'b0111; data_wdata = rt_value >> 8;  end
        default: begin data_wstrb = 4'b1111; data_wdata = rt_value;       end
      endcase
    end else if (mem_inst[11]) begin
      case (a)
        2'd0:    begin data_wstrb = 4'b1111; data_wdata = rt_value;       end
        2'd1:    begin data_wstrb = 4'b1110; data_wdata = rt_value << 8;  end
        2'd2:    begin data_wstrb = 4'b1100; data_wdata = rt_value << 16; end
        default: begin data_wstrb = 4'b1000; data_wdata = rt_value << 24; end
      endcase
    end
  end

  always_comb begin
    m1s_valid_d = m1s_valid_q;
    bus_d       = bus_q;
    if (flush) begin
      m1s_valid_d = 1'b0;
    end else if (m1s_allowin) begin
      m1s_valid_d = es_to_m1s_valid;
    end
    if (m1s_allowin && es_to_m1s_valid) begin
      bus_d = es_to_m1s_bus;
    end
  end

  // A request accepted while downstream stalls parks in DONE so it is not reissued.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req && !data_addr_ok)     state_d = WAIT;
          else if (handshake && !ms_allowin) state_d = DONE;
        end
        WAIT: begin
          if (handshake) state_d = ms_allowin ? IDLE : DONE;
        end
        DONE: begin
          if (ms_allowin) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m1s_valid_q <= 1'b0;
      bus_q       <= '0;
      state_q     <= IDLE;
    end else begin
      m1s_valid_q <= m1s_valid_d;
      bus_q       <= bus_d;
      state_q     <= state_d;
    end
  end

  assign m1s_to_ms_bus = {mfc0, CP0_data, ex, bus_q[114:0]};
  assign M1_dest       = dest & {5{m1s_to_ms_valid & gr_we}};
  assign M1_result     = mfc0 ? CP0_data : alu_result;
  assign m1s_ex        = m1s_valid_q & ex;

endmodule

// File: tb/tb_m1_stage.sv
// Directed bench for m1_stage: store strobes, dcache stalls, DONE parking,
// exceptions, flush and asynchronous reset.
module tb_m1_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         es_to_m1s_valid;
  logic         m1s_allowin;
  logic [116:0] es_to_m1s_bus;
  logic         ms_allowin;
  logic         m1s_to_ms_valid;
  logic [148:0] m1s_to_ms_bus;
  logic         flush;
  logic [31:0]  CP0_data;
  logic         data_req, data_wr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr, data_wdata;
  logic         data_addr_ok;
  logic [4:0]   M1_dest;
  logic [31:0]  M1_result;
  logic         m1s_ex;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [11:0] LW  = 12'h001, SW  = 12'h002, LH  = 12'h010;
  localparam logic [11:0] SB  = 12'h100, SH  = 12'h200, SWL = 12'h400, SWR = 12'h800;
  localparam logic [11:0] LB  = 12'h004, NOP = 12'h000;

  m1_stage u_dut (
    .clk(clk), .resetn(resetn),
    .es_to_m1s_valid(es_to_m1s_valid), .m1s_allowin(m1s_allowin),
    .es_to_m1s_bus(es_to_m1s_bus), .ms_allowin(ms_allowin),
    .m1s_to_ms_valid(m1s_to_ms_valid), .m1s_to_ms_bus(m1s_to_ms_bus),
    .flush(flush), .CP0_data(CP0_data),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .M1_dest(M1_dest), .M1_result(M1_result), .m1s_ex(m1s_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [116:0] mk(input logic mfc0, input logic ex_in,
                                      input logic [31:0] rt, input logic [11:0] mi,
                                      input logic gr_we, input logic [4:0] dest,
                                      input logic [31:0] alu);
    logic ld;
    ld = |(mi & 12'h0FD);
    return {mfc0, ex_in, rt, mi, ld, gr_we, dest, alu, 32'hBFC0_1234};
  endfunction

  // Present one instruction for a cycle; returns at posedge+1 with it resident.
  task automatic load(input logic [116:0] b);
    es_to_m1s_bus   = b;
    es_to_m1s_valid = 1'b1;
    @(posedge clk); #1;
    es_to_m1s_valid = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  task automatic store_vec(input string tag, input logic [11:0] mi, input logic [31:0] alu,
                           input logic [3:0] strb, input logic [31:0] wdata, input logic wr);
    load(mk(1'b0, 1'b0, 32'h1122_3344, mi, 1'b0, 5'd0, alu));
    check({tag, "_req"},   data_req, 1'b1);
    check({tag, "_addr"},  data_addr, {alu[31:2], 2'b00});
    check({tag, "_strb"},  data_wstrb, strb);
    check({tag, "_wr"},    data_wr, wr);
    if (wr) check({tag, "_wdata"}, data_wdata, wdata);
    check({tag, "_ovld"},  m1s_to_ms_valid, 1'b1);
    next_cycle();
  endtask

  initial begin
    resetn = 1'b0; es_to_m1s_valid = 1'b0; es_to_m1s_bus = '0;
    ms_allowin = 1'b1; flush = 1'b0; CP0_data = 32'h1234_5678; data_addr_ok = 1'b0;
    #3;
    check("rst_allowin", m1s_allowin, 1'b1);
    check("rst_req",     data_req, 1'b0);
    check("rst_ovld",    m1s_to_ms_valid, 1'b0);
    check("rst_dest",    M1_dest, 5'd0);
    check("rst_ex",      m1s_ex, 1'b0);
    #9 resetn = 1'b1;
    @(posedge clk); #1;

    // sb to byte 3, single-cycle pass
    data_addr_ok = 1'b1;
    load(mk(1'b0, 1'b0, 32'h0000_00AB, SB, 1'b0, 5'd0, 32'h0000_1003));
    check("sb_req",   data_req, 1'b1);
    check("sb_addr",  data_addr, 32'h0000_1000);
    check("sb_strb",  data_wstrb, 4'b1000);
    check("sb_wdata", data_wdata, 32'hABAB_ABAB);
    check("sb_ovld",  m1s_to_ms_valid, 1'b1);
    check("sb_obus",  m1s_to_ms_bus,
          {1'b0, 32'h1234_5678, 1'b0, mk(1'b0, 1'b0, 32'h0000_00AB, SB, 1'b0, 5'd0, 32'h0000_1003)} >> 0);
    next_cycle();
    check("sb_gone", m1s_to_ms_valid, 1'b0);

    store_vec("sw",   SW,  32'h100, 4'b1111, 32'h1122_3344, 1'b1);
    store_vec("sh2",  SH,  32'h102, 4'b1100, 32'h3344_3344, 1'b1);
    store_vec("sh0",  SH,  32'h100, 4'b0011, 32'h3344_3344, 1'b1);
    store_vec("sb1",  SB,  32'h101, 4'b0010, 32'h4444_4444, 1'b1);
    store_vec("swl0", SWL, 32'h0,   4'b0001, 32'h0000_0011, 1'b1);
    store_vec("swl1", SWL, 32'h1,   4'b0011, 32'h0000_1122, 1'b1);
    store_vec("swl2", SWL, 32'h2,   4'b0111, 32'h0011_2233, 1'b1);
    store_vec("swl3", SWL, 32'h3,   4'b1111, 32'h1122_3344, 1'b1);
    store_vec("swr0", SWR, 32'h0,   4'b1111, 32'h1122_3344, 1'b1);
    store_vec("swr1", SWR, 32'h1,   4'b1110, 32'h2233_4400, 1'b1);
    store_vec("swr2", SWR, 32'h2,   4'b1100, 32'h3344_0000, 1'b1);
    store_vec("swr3", SWR, 32'h3,   4'b1000, 32'h4400_0000, 1'b1);
    store_vec("lb",   LB,  32'h203, 4'b0000, 32'h0,         1'b0);

    // lw stalled by dcache for 3 cycles; a waiting upstream instruction must not intrude
    data_addr_ok = 1'b0;
    load(mk(1'b0, 1'b0, 32'h0, LW, 1'b1, 5'd5, 32'h0000_2000));
    es_to_m1s_bus   = mk(1'b0, 1'b0, 32'h0, SW, 1'b0, 5'd0, 32'h0000_4444);
    es_to_m1s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_req",  data_req, 1'b1);
      check("lw_wait_addr", data_addr, 32'h0000_2000);
      check("lw_wait_ovld", m1s_to_ms_valid, 1'b0);
      check("lw_wait_dest", M1_dest, 5'd0);
      check("lw_wait_alw",  m1s_allowin, 1'b0);
      next_cycle();
    end
    data_addr_ok = 1'b1; es_to_m1s_valid = 1'b0; #1;
    check("lw_ok_req",  data_req, 1'b1);
    check("lw_ok_addr", data_addr, 32'h0000_2000);
    check("lw_ok_ovld", m1s_to_ms_valid, 1'b1);
    check("lw_ok_dest", M1_dest, 5'd5);
    check("lw_ok_res",  M1_result, 32'h0000_2000);
    next_cycle();
    check("lw_gone_ovld", m1s_to_ms_valid, 1'b0);
    check("lw_gone_req",  data_req, 1'b0);

    // sw accepted under downstream stall parks in DONE
    ms_allowin = 1'b0;
    load(mk(1'b0, 1'b0, 32'hDEAD_BEEF, SW, 1'b0, 5'd0, 32'h0000_3000));
    check("done_issue_req",  data_req, 1'b1);
    check("done_issue_ovld", m1s_to_ms_valid, 1'b1);
    check("done_issue_alw",  m1s_allowin, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check("done_req",  data_req, 1'b0);
      check("done_ovld", m1s_to_ms_valid, 1'b1);
      check("done_alw",  m1s_allowin, 1'b0);
    end
    ms_allowin = 1'b1; #1;
    check("done_leave_alw", m1s_allowin, 1'b1);
    next_cycle();
    check("done_empty_ovld", m1s_to_ms_valid, 1'b0);
    check("done_empty_req",  data_req, 1'b0);

    // misaligned lh
    load(mk(1'b0, 1'b0, 32'h0, LH, 1'b1, 5'd7, 32'h0000_3001));
`ifdef ADDR_ERR_CHECK_EN
    check("lh_ae_req",  data_req, 1'b0);
    check("lh_ae_exb",  m1s_to_ms_bus[115], 1'b1);
    check("lh_ae_ex",   m1s_ex, 1'b1);
    check("lh_ae_ovld", m1s_to_ms_valid, 1'b1);
`else
    check("lh_na_req",  data_req, 1'b1);
    check("lh_na_addr", data_addr, 32'h0000_3000);
    check("lh_na_strb", data_wstrb, 4'b0000);
    check("lh_na_exb",  m1s_to_ms_bus[115], 1'b0);
    check("lh_na_ex",   m1s_ex, 1'b0);
    check("lh_na_ovld", m1s_to_ms_valid, 1'b1);
`endif
    next_cycle();

    // upstream exception suppresses the request
    data_addr_ok = 1'b0;
    load(mk(1'b0, 1'b1, 32'h0, LW, 1'b1, 5'd9, 32'h0000_3100));
    check("exin_req",  data_req, 1'b0);
    check("exin_ex",   m1s_ex, 1'b1);
    check("exin_exb",  m1s_to_ms_bus[115], 1'b1);
    check("exin_ovld", m1s_to_ms_valid, 1'b1);
    next_cycle();

    // mfc0 forwards CP0 data
    load(mk(1'b1, 1'b0, 32'h0, NOP, 1'b1, 5'd3, 32'h0000_0abc));
    check("mfc0_res",  M1_result, 32'h1234_5678);
    check("mfc0_cp0",  m1s_to_ms_bus[147:116], 32'h1234_5678);
    check("mfc0_flag", m1s_to_ms_bus[148], 1'b1);
    check("mfc0_dest", M1_dest, 5'd3);
    check("mfc0_req",  data_req, 1'b0);
    next_cycle();

    // flush while waiting on dcache
    load(mk(1'b0, 1'b0, 32'h0, LW, 1'b1, 5'd4, 32'h0000_5000));
    check("fl_wait_req", data_req, 1'b1);
    next_cycle();
    flush = 1'b1; #1;
    check("fl_req",  data_req, 1'b0);
    check("fl_ovld", m1s_to_ms_valid, 1'b0);
    check("fl_dest", M1_dest, 5'd0);
    next_cycle();
    flush = 1'b0; #1;
    check("fl_after_alw",  m1s_allowin, 1'b1);
    check("fl_after_req",  data_req, 1'b0);
    check("fl_after_ovld", m1s_to_ms_valid, 1'b0);
    check("fl_after_ex",   m1s_ex, 1'b0);
    data_addr_ok = 1'b1;
    load(mk(1'b0, 1'b0, 32'h0, LW, 1'b1, 5'd4, 32'h0000_5004));
    check("fl_next_req",  data_req, 1'b1);
    check("fl_next_ovld", m1s_to_ms_valid, 1'b1);
    next_cycle();

    // asynchronous reset while parked in DONE
    ms_allowin = 1'b0;
    load(mk(1'b0, 1'b0, 32'h55AA_55AA, SW, 1'b1, 5'd6, 32'h0000_7000));
    next_cycle();
    check("rd_done_req", data_req, 1'b0);
    #1 resetn = 1'b0; #1;
    check("rd_alw",  m1s_allowin, 1'b1);
    check("rd_req",  data_req, 1'b0);
    check("rd_ovld", m1s_to_ms_valid, 1'b0);
    check("rd_dest", M1_dest, 5'd0);
    check("rd_ex",   m1s_ex, 1'b0);
    check("rd_addr", data_addr, 32'h0);
    #1 resetn = 1'b1; ms_allowin = 1'b1;
    next_cycle();
    check("rd_noreissue", data_req, 1'b0);
    load(mk(1'b0, 1'b0, 32'h0, LW, 1'b1, 5'd2, 32'h0000_6000));
    check("rd_lw_req",  data_req, 1'b1);
    check("rd_lw_addr", data_addr, 32'h0000_6000);
    check("rd_lw_ovld", m1s_to_ms_valid, 1'b1);
    check("rd_lw_dest", M1_dest, 5'd2);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
